// File: rtl/if_fetch_unit_if.sv
// Bus bundle for the instruction-fetch stage: imem request/response, redirect and decode handshake.
// Signal prefixes keep the fetch unit's point of view (o_ = driven by the fetch unit).
interface if_fetch_unit_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
);
   logic               o_imem_req_valid;
   logic               i_imem_req_ready;
   logic [ADDR_W-1:0]  o_imem_req_addr;
   logic               i_imem_rsp_valid;
   logic [INSTR_W-1:0] i_imem_rsp_data;
   logic               i_redirect;
   logic [ADDR_W-1:0]  i_redirect_addr;
   logic               o_valid;
   logic               i_ready;
   logic [ADDR_W-1:0]  o_pc;
   logic [INSTR_W-1:0] o_instruction;

   modport master (
      output o_imem_req_valid, o_imem_req_addr, o_valid, o_pc, o_instruction,
      input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_redirect, i_redirect_addr, i_ready
   );

   modport slave (
      input  o_imem_req_valid, o_imem_req_addr, o_valid, o_pc, o_instruction,
      output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_redirect, i_redirect_addr, i_ready
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, pipelined in-order imem requests, prefetch queue,
// valid/ready delivery to decode, and redirect with discard of stale in-flight words.
module if_fetch_unit #(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        Q_DEPTH   = 4,
   parameter int unsigned        MAX_OUTST = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   if_fetch_unit_if.master bus
);
   localparam int unsigned QPW = $clog2(Q_DEPTH);
   localparam int unsigned CW  = $clog2(Q_DEPTH + 1);
   localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
   localparam int unsigned RPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned SW  = CW + OW + 1;

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_W / 8);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_W / 8 - 1);
   localparam logic [OW-1:0]     MAX_O      = OW'(MAX_OUTST);
   localparam logic [SW-1:0]     QD         = SW'(Q_DEPTH);
   localparam logic [CW-1:0]     CNT_FULL   = CW'(Q_DEPTH);
   localparam logic [RPW-1:0]    RP_LAST    = RPW'(MAX_OUTST - 1);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [OW-1:0]      outst_q, outst_d;
   logic [OW-1:0]      drop_q, drop_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [QPW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [RPW-1:0]     rp_rd_q, rp_rd_d, rp_wr_q, rp_wr_d;

   logic [ADDR_W-1:0]  q_pc  [Q_DEPTH];
   logic [INSTR_W-1:0] q_ins [Q_DEPTH];
   logic [ADDR_W-1:0]  rp_mem [MAX_OUTST];

   logic          req_ok, acc, rsp, push, pop, valid;
   logic [SW-1:0] occ;

   // Slots already promised to live in-flight words count against the queue.
   assign occ    = SW'(cnt_q) + SW'(outst_q) - SW'(drop_q);
   assign req_ok = !i_reset && (outst_q < MAX_O) && (occ < QD);
   assign acc    = req_ok && bus.i_imem_req_ready;
   assign rsp    = bus.i_imem_rsp_valid;
   assign valid  = (cnt_q != '0);
   assign push   = rsp && (drop_q == '0) && !bus.i_redirect;
   assign pop    = valid && bus.i_ready && !bus.i_redirect;

   always_comb begin
      pc_d    = pc_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rp_rd_d = rp_rd_q;
      rp_wr_d = rp_wr_q;
      outst_d = outst_q + OW'(acc) - OW'(rsp);
      if (acc) rp_wr_d = (rp_wr_q == RP_LAST) ? '0 : rp_wr_q + RPW'(1);
      if (rsp) rp_rd_d = (rp_rd_q == RP_LAST) ? '0 : rp_rd_q + RPW'(1);
      if (bus.i_redirect) begin
         // Everything still in flight after this edge belongs to the old path.
         pc_d   = bus.i_redirect_addr & ~ALIGN_MASK;
         drop_d = outst_d;
         cnt_d  = '0;
         rd_d   = '0;
         wr_d   = '0;
      end else begin
         if (acc) pc_d = pc_q + STEP;
         if (rsp && (drop_q != '0)) drop_d = drop_q - OW'(1);
         if (push) wr_d = wr_q + QPW'(1);
         if (pop)  rd_d = rd_q + QPW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         rp_rd_q <= '0;
         rp_wr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rp_rd_q <= rp_rd_d;
         rp_wr_q <= rp_wr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (acc) rp_mem[rp_wr_q] <= pc_q;
      if (push) begin
         q_pc[wr_q]  <= rp_mem[rp_rd_q];
         q_ins[wr_q] <= bus.i_imem_rsp_data;
      end
   end

   assign bus.o_imem_req_valid = req_ok;
   assign bus.o_imem_req_addr  = pc_q;
   assign bus.o_valid          = valid;
   assign bus.o_pc             = valid ? q_pc[rd_q]  : '0;
   assign bus.o_instruction    = valid ? q_ins[rd_q] : '0;

   a_rsp_needs_outst: assert property (@(posedge i_clk) disable iff (i_reset)
      rsp |-> (outst_q != '0));
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
      !(push && !pop && (cnt_q == CNT_FULL)));
   a_drop_le_outst: assert property (@(posedge i_clk) disable iff (i_reset)
      drop_q <= outst_q);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: in-order memory model plus a scoreboard of the
// instruction stream decode should see, checked by an independent monitor process.
module tb_if_fetch_unit;
   localparam int unsigned QD  = 4;
   localparam logic [31:0] RPC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic rst;

   if_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   if_fetch_unit #(
      .ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC), .Q_DEPTH(QD), .MAX_OUTST(2)
   ) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] pend[$];
   logic [31:0] acc_log[$];
   logic [31:0] next_addr = RPC;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   int unsigned n_hs = 0;
   bit          after_flush = 1'b0;
   bit          want_first = 1'b0;
   logic [31:0] want_pc = '0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then apply the coming edge to the reference model.
   task automatic step(input bit r, input bit rd, input logic [31:0] tgt,
                       input bit rdy, input bit mrdy, input bit rsp_en);
      bit rsp, acc;
      @(negedge clk);
      rst                  = r;
      bus.i_redirect       = rd;
      bus.i_redirect_addr  = tgt;
      bus.i_ready          = rdy;
      bus.i_imem_req_ready = mrdy;
      rsp = !r && rsp_en && (pend.size() > 0);
      bus.i_imem_rsp_valid = rsp;
      bus.i_imem_rsp_data  = rsp ? instr_of(pend[0]) : $urandom;
      #1;
      if (after_flush) begin
         chk("flush_valid", 32'(bus.o_valid), 32'd0);
         chk("flush_pc", bus.o_pc, 32'd0);
      end
      after_flush = r || rd;
      acc = bus.o_imem_req_valid && mrdy;
      if (r) begin
         chk("req_valid_in_reset", 32'(bus.o_imem_req_valid), 32'd0);
         pend.delete();
         exp_q.delete();
         acc_log.delete();
         next_addr = RPC;
      end else begin
         if (acc) begin
            chk("req_addr", bus.o_imem_req_addr, next_addr);
            acc_log.push_back(bus.o_imem_req_addr);
         end
         if (rsp) void'(pend.pop_front());
         if (acc) pend.push_back(bus.o_imem_req_addr);
         if (rd) begin
            exp_q.delete();
            next_addr = tgt & ~32'h3;
         end else if (acc) begin
            exp_q.push_back({next_addr, instr_of(next_addr)});
            next_addr = next_addr + 32'd4;
         end
      end
   endtask

   initial begin : monitor
      bit          held_v;
      logic [31:0] held_pc, held_ins;
      int unsigned idle;
      item_t       e;
      held_v = 1'b0;
      held_pc = '0;
      held_ins = '0;
      idle = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst || bus.i_redirect) begin
            held_v = 1'b0;
            idle = 0;
            continue;
         end
         if (held_v) begin
            chk("hold_valid", 32'(bus.o_valid), 32'd1);
            chk("hold_pc", bus.o_pc, held_pc);
            chk("hold_instr", bus.o_instruction, held_ins);
         end
         if (!bus.o_valid) begin
            chk("idle_pc", bus.o_pc, 32'd0);
            chk("idle_instr", bus.o_instruction, 32'd0);
         end
         if (bus.o_valid && bus.i_ready) begin
            n_hs++;
            idle = 0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_word: got pc 0x%08h, expected no word", bus.o_pc);
            end else begin
               e = exp_q.pop_front();
               chk("dec_pc", bus.o_pc, e.pc);
               chk("dec_instr", bus.o_instruction, e.ins);
               if (want_first) begin
                  chk("redirect_first_pc", bus.o_pc, want_pc);
                  want_first = 1'b0;
               end
            end
         end else if (bus.i_ready && (exp_q.size() > 0)) begin
            idle++;
            if (idle == 64) begin
               n_cmp++;
               n_fail++;
               $display("FAIL delivery_timeout: got no word for 64 cycles, expected pc 0x%08h",
                        exp_q[0].pc);
            end
         end
         held_v   = bus.o_valid && !bus.i_ready;
         held_pc  = bus.o_pc;
         held_ins = bus.o_instruction;
      end
   end

   initial begin : stimulus
      logic [31:0] t5 [4];
      int unsigned h0;
      t5[0] = 32'hFFFF_FFF8;
      t5[1] = 32'hFFFF_FFFC;
      t5[2] = 32'h0000_0000;
      t5[3] = 32'h0000_0004;
      rst = 1'b1;
      bus.i_redirect = 1'b0;
      bus.i_redirect_addr = '0;
      bus.i_ready = 1'b0;
      bus.i_imem_req_ready = 1'b0;
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data = '0;

      repeat (3) step(1, 0, 0, 0, 0, 0);

      // Streaming with zero-wait memory, starting near the top of the address space.
      repeat (10) step(0, 0, 0, 1, 1, 1);
      h0 = n_hs;
      repeat (20) step(0, 0, 0, 1, 1, 1);
      chk("throughput", n_hs - h0, 32'd20);
      for (int unsigned i = 0; i < 4; i++) chk("wrap_addr", acc_log[i], t5[i]);

      // Decode stall: queue fills to capacity and issue stops.
      repeat (20) step(0, 0, 0, 0, 1, 1);
      chk("stall_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
      chk("stall_inflight", 32'(pend.size()), 32'd0);
      chk("stall_buffered", 32'(exp_q.size()), QD);
      chk("stall_valid", 32'(bus.o_valid), 32'd1);
      repeat (10) step(0, 0, 0, 1, 1, 1);

      // Redirect with two requests in flight.
      for (int i = 0; i < 8 && pend.size() < 2; i++) step(0, 0, 0, 1, 1, 0);
      chk("t3_inflight", 32'(pend.size()), 32'd2);
      step(0, 1, 32'h0000_0103, 1, 0, 0);
      want_first = 1'b1;
      want_pc = 32'h0000_0100;
      repeat (20) step(0, 0, 0, 1, 1, 1);
      chk("t3_first_seen", 32'(want_first), 32'd0);

      // Redirect coinciding with a request accept and a response.
      for (int i = 0; i < 8 && pend.size() > 0; i++) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 0);
      chk("t4_inflight", 32'(pend.size()), 32'd1);
      step(0, 1, 32'h0000_2000, 1, 1, 1);
      chk("t4_accept_at_redirect", 32'(bus.o_imem_req_valid), 32'd1);
      want_first = 1'b1;
      want_pc = 32'h0000_2000;
      repeat (20) step(0, 0, 0, 1, 1, 1);
      chk("t4_first_seen", 32'(want_first), 32'd0);

      // Random traffic with occasional redirects and resets.
      repeat (400) begin
         bit r, d;
         logic [31:0] tgt;
         r = ($urandom_range(99) < 1);
         d = ($urandom_range(99) < 3);
         tgt = $urandom;
         step(r, d, tgt, $urandom_range(3) != 0, $urandom_range(9) < 7, $urandom_range(9) < 6);
      end
      repeat (15) step(0, 0, 0, 1, 1, 1);

      // Reset with a full queue, then refetch from the reset PC.
      repeat (12) step(0, 0, 0, 0, 1, 1);
      chk("t6_full", 32'(exp_q.size()), QD);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      repeat (20) step(0, 0, 0, 1, 1, 1);
      chk("t6_refetch_addr", acc_log[0], RPC);

      repeat (10) step(0, 0, 0, 1, 1, 1);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
